// File: rtl/data_mem_responder_if.sv
// Core-side data memory port: request/store fields in, load data and status out.
// Enabled by the master (core) and consumed by the slave (responder) modports.
interface data_mem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [2:0]  size_i;
   logic [31:0] addr_i;
   logic [31:0] wd_i;
   logic [31:0] rd_o;
   logic        stall_o;
   logic        err_o;

   modport master (
      output req_i, we_i, size_i, addr_i, wd_i,
      input  rd_o, stall_o, err_o
   );

   modport slave (
      input  req_i, we_i, size_i, addr_i, wd_i,
      output rd_o, stall_o, err_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory with WAIT_STATES stall cycles per access; combinational load path.
// Optional misalignment check enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic                 clk_i,
   input logic                 rst_i,
   data_mem_responder_if.slave bus
);

   localparam int          AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic          below_ws;
   logic          stall, done, mis, wr_en;
   logic          sz_b, sz_h, sz_w, sgn;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;
   logic [31:0]   rd, wdat;
   logic [3:0]    be;
   logic          unused_addr_bits;

   assign idx  = bus.addr_i[AW+1:2];
   assign word = mem[idx];
   assign unused_addr_bits = ^bus.addr_i[31:AW+2];

   // Zero wait states would make the comparison constant, so tie it off explicitly.
   if (WAIT_STATES == 0) begin : g_nowait
      assign below_ws = 1'b0;
   end else begin : g_wait
      assign below_ws = (cnt_q < WS);
   end

   always_comb begin
      sz_b  = (bus.size_i == 3'd0) || (bus.size_i == 3'd4);
      sz_h  = (bus.size_i == 3'd1) || (bus.size_i == 3'd5);
      sz_w  = (bus.size_i == 3'd2);
      sgn   = ~bus.size_i[2];
      mis   = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis   = (sz_h & bus.addr_i[0]) | (sz_w & (|bus.addr_i[1:0]));
`endif
      stall = bus.req_i & below_ws;
      done  = bus.req_i & ~stall;
      rbyte = word[{bus.addr_i[1:0], 3'b000} +: 8];
      rhalf = bus.addr_i[1] ? word[31:16] : word[15:0];

      rd = 32'h0;
      if (bus.req_i && !bus.we_i && !mis) begin
         if (sz_b)      rd = {{24{sgn & rbyte[7]}}, rbyte};
         else if (sz_h) rd = {{16{sgn & rhalf[15]}}, rhalf};
         else if (sz_w) rd = word;
      end

      be   = 4'b0000;
      wdat = bus.wd_i;
      if (sz_b) begin
         be   = 4'b0001 << bus.addr_i[1:0];
         wdat = {4{bus.wd_i[7:0]}};
      end else if (sz_h) begin
         be   = bus.addr_i[1] ? 4'b1100 : 4'b0011;
         wdat = {2{bus.wd_i[15:0]}};
      end else if (sz_w) begin
         be   = 4'b1111;
      end

      // Reset blocks the commit even if a zero-wait request is present.
      wr_en = rst_i & done & bus.we_i & ~mis;
      cnt_d = stall ? cnt_q + 4'd1 : 4'd0;
   end

   assign bus.rd_o    = rd;
   assign bus.stall_o = stall;
   assign bus.err_o   = rst_i & done & mis;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en && be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: byte-addressed model checked every cycle against a WAIT_STATES=2 and a WAIT_STATES=0 instance.
module tb_data_mem_responder;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
   } in_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   data_mem_responder_if ia();
   data_mem_responder_if ib();

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .bus(ia)
   );
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .bus(ib)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;
   int   age [2];
   logic [7:0] mm [2][4096];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int ws(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic in_t cur_in(input int d);
      in_t r;
      if (d == 0) r = {ia.req_i, ia.we_i, ia.size_i, ia.addr_i, ia.wd_i};
      else        r = {ib.req_i, ib.we_i, ib.size_i, ib.addr_i, ib.wd_i};
      return r;
   endfunction

   function automatic logic mis_m(input logic [2:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
      return (((sz == 3'd1) || (sz == 3'd5)) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   // Load result from the byte-level model; wrap is modulo 4 KiB of bytes.
   function automatic logic [31:0] exp_rd(input int d, input in_t v);
      logic [11:0] b;
      logic [7:0]  b0, b1, b2, b3;
      if (!v.req || v.we || mis_m(v.sz, v.a)) return 32'h0;
      case (v.sz)
         3'd0, 3'd4: begin
            b  = v.a[11:0];
            b0 = mm[d][b];
            return (v.sz == 3'd0) ? {{24{b0[7]}}, b0} : {24'h0, b0};
         end
         3'd1, 3'd5: begin
            b  = {v.a[11:1], 1'b0};
            b0 = mm[d][b];
            b1 = mm[d][b + 12'd1];
            return (v.sz == 3'd1) ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
         end
         3'd2: begin
            b  = {v.a[11:2], 2'b00};
            b0 = mm[d][b];
            b1 = mm[d][b + 12'd1];
            b2 = mm[d][b + 12'd2];
            b3 = mm[d][b + 12'd3];
            return {b3, b2, b1, b0};
         end
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input int d, input in_t v);
      logic [11:0] b;
      if (mis_m(v.sz, v.a)) return;
      case (v.sz)
         3'd0, 3'd4: mm[d][v.a[11:0]] = v.wd[7:0];
         3'd1, 3'd5: begin
            b = {v.a[11:1], 1'b0};
            mm[d][b]         = v.wd[7:0];
            mm[d][b + 12'd1] = v.wd[15:8];
         end
         3'd2: begin
            b = {v.a[11:2], 2'b00};
            for (int k = 0; k < 4; k++) mm[d][b + 12'(k)] = v.wd[8*k +: 8];
         end
         default: ;
      endcase
   endtask

   // age = cycles the current request has already waited; any idle cycle or reset restarts it.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         in_t v;
         bit  es;
         v  = cur_in(d);
         es = v.req && (age[d] < ws(d));
         if (!rst_n || !v.req) age[d] = 0;
         else if (es)          age[d] = age[d] + 1;
         else begin
            age[d] = 0;
            if (v.we) model_write(d, v);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            in_t         v;
            int          eff;
            bit          es, dn;
            logic [31:0] er;
            logic        st, er_o;
            logic [31:0] rd;
            v   = cur_in(d);
            eff = rst_n ? age[d] : 0;
            es  = v.req && (eff < ws(d));
            dn  = rst_n && v.req && !es;
            st   = (d == 0) ? ia.stall_o : ib.stall_o;
            er_o = (d == 0) ? ia.err_o   : ib.err_o;
            rd   = (d == 0) ? ia.rd_o    : ib.rd_o;
            chk($sformatf("stall_d%0d", d), {31'b0, st}, {31'b0, es});
            chk($sformatf("err_d%0d", d), {31'b0, er_o}, {31'b0, dn && mis_m(v.sz, v.a)});
            er = exp_rd(d, v);
            if (!$isunknown(er)) chk($sformatf("rd_d%0d", d), rd, er);
         end
      end
   end

   task automatic set_in(input int d, input bit we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         ia.req_i = 1'b1; ia.we_i = we; ia.size_i = sz; ia.addr_i = a; ia.wd_i = wd;
      end else begin
         ib.req_i = 1'b1; ib.we_i = we; ib.size_i = sz; ib.addr_i = a; ib.wd_i = wd;
      end
   endtask

   task automatic drop(input int d);
      if (d == 0) ia.req_i = 1'b0;
      else        ib.req_i = 1'b0;
   endtask

   // One access; returns completion-cycle rd/err and the number of stall cycles seen.
   task automatic acc(input int d, input bit we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int abort_after, input bit hold,
                      output logic [31:0] rd, output int stalls, output logic err);
      set_in(d, we, sz, a, wd);
      stalls = 0; rd = 32'h0; err = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (((d == 0) ? ia.stall_o : ib.stall_o) == 1'b0) begin
            rd  = (d == 0) ? ia.rd_o  : ib.rd_o;
            err = (d == 0) ? ia.err_o : ib.err_o;
            @(posedge clk); #1;
            if (!hold) drop(d);
            return;
         end
         stalls++;
         if (stalls == abort_after) begin
            @(posedge clk); #1;
            drop(d);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      n_cmp++; n_bad++;
      $display("FAIL acc_timeout: no completion within 40 cycles at %0t", $time);
      drop(d);
   endtask

   logic [31:0] r;
   int          s;
   logic        e;

   initial begin
      ia.req_i = 0; ia.we_i = 0; ia.size_i = 0; ia.addr_i = 0; ia.wd_i = 0;
      ib.req_i = 0; ib.we_i = 0; ib.size_i = 0; ib.addr_i = 0; ib.wd_i = 0;
      age[0] = 0; age[1] = 0;
      rst_n  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_stall_idle", {31'b0, ia.stall_o}, 32'h0);
      chk("rst_err_idle", {31'b0, ia.err_o}, 32'h0);
      set_in(0, 1'b0, 3'd2, 32'h0, 32'h0);
      @(negedge clk);
      chk("rst_stall_req", {31'b0, ia.stall_o}, 32'h1);
      @(posedge clk); #1;
      drop(0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Store then load, full wait-state timing.
      acc(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, -1, 0, r, s, e);
      chk("sw_stalls", s, 2);
      acc(0, 0, 3'd2, 32'h10, 32'h0, -1, 0, r, s, e);
      chk("lw_deadbeef", r, 32'hDEADBEEF);
      chk("lw_stalls", s, 2);

      // Byte store into a zero word, then every load width.
      acc(0, 1, 3'd2, 32'h10, 32'h0, -1, 0, r, s, e);
      acc(0, 1, 3'd0, 32'h13, 32'h80, -1, 0, r, s, e);
      acc(0, 0, 3'd2, 32'h10, 32'h0, -1, 0, r, s, e);
      chk("lw_after_sb", r, 32'h80000000);
      acc(0, 0, 3'd0, 32'h13, 32'h0, -1, 0, r, s, e);
      chk("lb_sign", r, 32'hFFFFFF80);
      acc(0, 0, 3'd4, 32'h13, 32'h0, -1, 0, r, s, e);
      chk("lbu_zero", r, 32'h00000080);
      acc(0, 0, 3'd1, 32'h12, 32'h0, -1, 0, r, s, e);
      chk("lh_sign", r, 32'hFFFF8000);

      // Back-to-back with req held across completion.
      acc(0, 1, 3'd2, 32'h20, 32'h11223344, -1, 1, r, s, e);
      acc(0, 0, 3'd2, 32'h20, 32'h0, -1, 0, r, s, e);
      chk("b2b_stalls", s, 2);
      chk("b2b_rd", r, 32'h11223344);

      // Request withdrawn after one stall: no write, next access waits in full.
      acc(0, 1, 3'd2, 32'h40, 32'hCAFEF00D, -1, 0, r, s, e);
      acc(0, 1, 3'd2, 32'h40, 32'h0BADBEEF, 1, 0, r, s, e);
      acc(0, 0, 3'd2, 32'h40, 32'h0, -1, 0, r, s, e);
      chk("abort_nowrite", r, 32'hCAFEF00D);
      chk("abort_restall", s, 2);

      // Address wrap and unsupported sizes.
      acc(0, 1, 3'd2, 32'h1000, 32'h5, -1, 0, r, s, e);
      acc(0, 0, 3'd2, 32'h0, 32'h0, -1, 0, r, s, e);
      chk("wrap", r, 32'h5);
      acc(0, 1, 3'd2, 32'h50, 32'h01020304, -1, 0, r, s, e);
      acc(0, 1, 3'd3, 32'h50, 32'hFFFFFFFF, -1, 0, r, s, e);
      acc(0, 0, 3'd7, 32'h50, 32'h0, -1, 0, r, s, e);
      chk("bad_size_rd", r, 32'h0);
      acc(0, 0, 3'd2, 32'h50, 32'h0, -1, 0, r, s, e);
      chk("bad_size_nowrite", r, 32'h01020304);

`ifdef DMEM_MISALIGN_CHECK_EN
      acc(0, 0, 3'd2, 32'h41, 32'h0, -1, 0, r, s, e);
      chk("mis_lw_rd", r, 32'h0);
      chk("mis_lw_err", {31'b0, e}, 32'h1);
      chk("mis_lw_stalls", s, 2);
      acc(0, 1, 3'd2, 32'h41, 32'hFFFFFFFF, -1, 0, r, s, e);
      acc(0, 0, 3'd2, 32'h40, 32'h0, -1, 0, r, s, e);
      chk("mis_sw_nowrite", r, 32'hCAFEF00D);
`else
      acc(0, 0, 3'd2, 32'h41, 32'h0, -1, 0, r, s, e);
      chk("lw_ignore_low", r, 32'hCAFEF00D);
      chk("lw_no_err", {31'b0, e}, 32'h0);
      acc(0, 0, 3'd1, 32'h43, 32'h0, -1, 0, r, s, e);
      chk("lh_ignore_bit0", r, 32'hFFFFCAFE);
`endif

      // Reset in the middle of a store aborts it.
      acc(0, 1, 3'd2, 32'h60, 32'h1, -1, 0, r, s, e);
      set_in(0, 1'b1, 3'd2, 32'h60, 32'h99);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drop(0);
      @(posedge clk); #1;
      // Reset during a held load; the load restarts with full stall on release.
      set_in(0, 1'b0, 3'd2, 32'h60, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      acc(0, 0, 3'd2, 32'h60, 32'h0, -1, 0, r, s, e);
      chk("rst_abort_nowrite", r, 32'h1);
      chk("rst_restart_stalls", s, 2);

      // Zero wait states.
      acc(1, 1, 3'd1, 32'h22, 32'h1234, -1, 0, r, s, e);
      chk("ws0_sh_stalls", s, 0);
      acc(1, 0, 3'd5, 32'h22, 32'h0, -1, 1, r, s, e);
      chk("ws0_lhu", r, 32'h00001234);
      chk("ws0_lhu_stalls", s, 0);
      acc(1, 0, 3'd0, 32'h23, 32'h0, -1, 0, r, s, e);
      chk("ws0_lb", r, 32'h00000012);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
